// File: rtl/hwpe_ctrl_job_sched_pkg.sv
// hwpe_ctrl_job_sched_pkg: shared sizing limits, scheduler state and regfile/engine-side structs
package hwpe_ctrl_job_sched_pkg;
    localparam int unsigned REGFILE_N_MAX_CONTEXT = 8;
    localparam int unsigned REGFILE_N_MAX_CORES   = 16;
    localparam int unsigned REGFILE_N_EVT         = 2;
    localparam int unsigned SCHED_CW = $clog2(REGFILE_N_MAX_CONTEXT);
    localparam int unsigned SCHED_PW = $clog2(REGFILE_N_MAX_CONTEXT + 1);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} sched_state_t;
    typedef struct packed {
        logic                start;
        logic [SCHED_CW-1:0] ctx;
    } ctrl_sched_t;
    typedef struct packed {
        logic                done;
        logic                is_working;
        logic [SCHED_PW-1:0] pending;
        logic                overflow;
    } flags_sched_t;
    function automatic int unsigned ctx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/hwpe_ctrl_sched_fifo.sv
// hwpe_ctrl_sched_fifo: W-bit FIFO of DEPTH entries with sync clear.
// Ports: clk_i, rst_i (async), clear_i, push_i/data_i, pop_i/data_o (head), full_o, empty_o, count_o.
// Pushes while full and pops while empty are ignored.
module hwpe_ctrl_sched_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 1,
    parameter int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [W-1:0]    data_i,
    input  logic            pop_i,
    output logic [W-1:0]    data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CNTW-1:0] count_o
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = count_o == CNTW'(DEPTH);
    assign empty_o = count_o == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (clear_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count_o <= count_o + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wr_ptr] <= data_i;
    end
endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// hwpe_ctrl_job_sched: queues triggered contexts and runs them one at a time on the engine.
// Ports: trigger_i/trigger_ctx_i/trigger_ready_o (enqueue), start_o/ctx_o/engine_done_i (engine),
// done_o/evt_o (release + per-core events), is_working_o/pending_o/overflow_o (status), clear_i (soft clear).
module hwpe_ctrl_job_sched
    import hwpe_ctrl_job_sched_pkg::*;
#(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_CORES   = 8,
    parameter int unsigned N_EVT     = REGFILE_N_EVT,
    parameter int unsigned CW        = ctx_width(N_CONTEXT),
    parameter int unsigned PW        = $clog2(N_CONTEXT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     trigger_i,
    input  logic [CW-1:0]            trigger_ctx_i,
    output logic                     trigger_ready_o,
    output logic                     start_o,
    output logic [CW-1:0]            ctx_o,
    input  logic                     engine_done_i,
    output logic                     done_o,
    output logic [N_CORES*N_EVT-1:0] evt_o,
    output logic                     is_working_o,
    output logic [PW-1:0]            pending_o,
    output logic                     overflow_o
);
    sched_state_t  state, state_n;
    logic          full, empty, pop;
    logic [CW-1:0] head;

    hwpe_ctrl_sched_fifo #(.DEPTH(N_CONTEXT), .W(CW)) i_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (trigger_i),
        .data_i  (trigger_ctx_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (pending_o)
    );

    assign trigger_ready_o = !full;
    assign pop             = (state == IDLE) && !empty;
    assign start_o         = state == START;
    assign done_o          = state == DONE;
    assign is_working_o    = (state == START) || (state == RUN);

    // Only event line 0 (job done) is ever driven.
    always_comb begin
        evt_o = '0;
        for (int c = 0; c < int'(N_CORES); c++) evt_o[c*N_EVT] = done_o;
    end

    // START always advances, so an engine_done_i in the start cycle is dropped.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  state_n = empty ? IDLE : START;
            START: state_n = RUN;
            RUN:   state_n = engine_done_i ? DONE : RUN;
            DONE:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ctx_o      <= '0;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            ctx_o      <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_n;
            if (pop) ctx_o <= head;
            if (trigger_i && full) overflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// tb_hwpe_ctrl_job_sched: directed self-checking bench for the job scheduler (N_CONTEXT=2, 8 cores).
module tb_hwpe_ctrl_job_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        trigger = 1'b0;
    logic [0:0]  trigger_ctx = '0;
    logic        trigger_ready;
    logic        start;
    logic [0:0]  ctx;
    logic        engine_done = 1'b0;
    logic        done;
    logic [15:0] evt;
    logic        is_working;
    logic [1:0]  pending;
    logic        overflow;
    int          total = 0;
    int          bad = 0;

    localparam logic [15:0] EVT_DONE = 16'h5555;

    hwpe_ctrl_job_sched #(.N_CONTEXT(2), .N_CORES(8), .N_EVT(2)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .clear_i         (clear),
        .trigger_i       (trigger),
        .trigger_ctx_i   (trigger_ctx),
        .trigger_ready_o (trigger_ready),
        .start_o         (start),
        .ctx_o           (ctx),
        .engine_done_i   (engine_done),
        .done_o          (done),
        .evt_o           (evt),
        .is_working_o    (is_working),
        .pending_o       (pending),
        .overflow_o      (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_start"}, 32'(start), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_evt"}, 32'(evt), 0);
        chk({tag, "_working"}, 32'(is_working), 0);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_ready"}, 32'(trigger_ready), 1);
        chk({tag, "_ctx"}, 32'(ctx), 0);
    endtask

    initial begin
        #2;
        chk_idle_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        // single job, ctx 1
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        chk("single_pending", 32'(pending), 1);
        chk("single_nostart_yet", 32'(start), 0);
        tick();
        chk("single_start", 32'(start), 1);
        chk("single_ctx", 32'(ctx), 1);
        chk("single_working", 32'(is_working), 1);
        chk("single_pending0", 32'(pending), 0);
        tick();
        chk("single_start_pulse", 32'(start), 0);
        chk("single_run_working", 32'(is_working), 1);
        tick(); tick(); tick();
        chk("single_run_nodone", 32'(done), 0);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("single_done", 32'(done), 1);
        chk("single_evt", 32'(evt), 32'(EVT_DONE));
        chk("single_done_notworking", 32'(is_working), 0);
        chk("single_done_ctx", 32'(ctx), 1);
        tick();
        chk("single_done_pulse", 32'(done), 0);
        chk("single_evt_pulse", 32'(evt), 0);
        // spurious engine_done in IDLE
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("spur_idle_done", 32'(done), 0);
        chk("spur_idle_working", 32'(is_working), 0);
        // spurious engine_done in START (ctx 0 job)
        trigger = 1'b1; trigger_ctx = 1'b0;
        tick();
        trigger = 1'b0;
        tick();
        chk("spur_start_is_start", 32'(start), 1);
        chk("spur_start_ctx", 32'(ctx), 0);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("spur_start_done", 32'(done), 0);
        chk("spur_start_run", 32'(is_working), 1);
        tick();
        chk("spur_start_still_run", 32'(is_working), 1);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("spur_start_final_done", 32'(done), 1);
        tick();
        // fill queue while a ctx 1 job runs
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        chk("fill_run", 32'(is_working), 1);
        trigger = 1'b1; trigger_ctx = 1'b0;
        tick();
        chk("fill_pending1", 32'(pending), 1);
        trigger_ctx = 1'b1;
        tick();
        chk("fill_pending2", 32'(pending), 2);
        chk("fill_not_ready", 32'(trigger_ready), 0);
        chk("fill_no_overflow_yet", 32'(overflow), 0);
        trigger_ctx = 1'b0;
        tick();
        trigger = 1'b0;
        chk("fill_overflow", 32'(overflow), 1);
        chk("fill_pending_kept", 32'(pending), 2);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        chk("fill_idle_pending", 32'(pending), 2);
        tick();
        chk("fill_first_start", 32'(start), 1);
        chk("fill_first_ctx", 32'(ctx), 0);
        chk("fill_first_pending", 32'(pending), 1);
        tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        tick();
        chk("fill_second_start", 32'(start), 1);
        chk("fill_second_ctx", 32'(ctx), 1);
        chk("fill_second_pending", 32'(pending), 0);
        chk("fill_overflow_sticky", 32'(overflow), 1);
        tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        // simultaneous push/pop: queue ctx 1 during RUN, push ctx 0 in the IDLE pop cycle
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        chk("pp_pending_run", 32'(pending), 1);
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        trigger = 1'b1; trigger_ctx = 1'b0;
        chk("pp_idle_pending", 32'(pending), 1);
        tick();
        trigger = 1'b0;
        chk("pp_start", 32'(start), 1);
        chk("pp_start_ctx", 32'(ctx), 1);
        chk("pp_pending_kept", 32'(pending), 1);
        tick();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        tick();
        tick();
        chk("pp_next_start", 32'(start), 1);
        chk("pp_next_ctx", 32'(ctx), 0);
        chk("pp_next_pending", 32'(pending), 0);
        tick();
        // clear during RUN with one pending
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        chk("clr_pre_pending", 32'(pending), 1);
        chk("clr_pre_overflow", 32'(overflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_idle_outputs("clr");
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("clr_late_done", 32'(done), 0);
        chk("clr_late_evt", 32'(evt), 0);
        tick();
        chk("clr_after_done", 32'(done), 0);
        chk("clr_after_working", 32'(is_working), 0);
        // asynchronous reset mid-RUN with one pending
        trigger = 1'b1; trigger_ctx = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        trigger = 1'b1; trigger_ctx = 1'b0;
        tick();
        trigger = 1'b0;
        chk("rst_pre_working", 32'(is_working), 1);
        chk("rst_pre_pending", 32'(pending), 1);
        #2 rst = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        tick();
        rst = 1'b0;
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("rst_late_done", 32'(done), 0);
        tick();
        chk("rst_after_done", 32'(done), 0);
        chk("rst_after_working", 32'(is_working), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hwpe_ctrl_job_sched.md
Name: hwpe_ctrl_job_sched

Overview:
Multi-context job scheduler between the HWPE control register file and the engine datapath.
- Accepts committed/triggered context IDs from the regfile slave and queues them in order.
- Dispatches one job at a time to the engine (start pulse plus running context ID) and waits for engine completion.
- On completion, releases the context back to the regfile (done pulse) and broadcasts per-core completion events.

Parameters:
- N_CONTEXT, 2: number of job contexts; must be ≥1 and ≤ REGFILE_N_MAX_CONTEXT (8); queue depth equals N_CONTEXT.
- N_CORES, 8: number of event-receiving cores; ≤ REGFILE_N_MAX_CORES (16).
- N_EVT, 2: event lines per core (REGFILE_N_EVT); line 0 is job-done.
- CW, $clog2(N_CONTEXT) (min 1): context ID width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  synchronous soft clear (from SOFTCLEAR register)
- trigger_i  in  1  single-cycle request to enqueue a context
- trigger_ctx_i  in  CW  context ID accompanying trigger_i
- trigger_ready_o  out  1  queue not full
- start_o  out  1  single-cycle engine start
- ctx_o  out  CW  context of job in flight (valid while is_working_o)
- engine_done_i  in  1  single-cycle engine completion
- done_o  out  1  single-cycle context release to regfile
- evt_o  out  N_CORES*N_EVT  per-core event pulses, [core][evt]
- is_working_o  out  1  job in START or RUN
- pending_o  out  $clog2(N_CONTEXT+1)  queued (not yet dispatched) jobs
- overflow_o  out  1  sticky: trigger dropped while full

Behaviour:
- Interface: one clock clk_i; reset rst_i is asynchronous and active-high.
- Reset and clear_i (clear_i has priority over all other inputs):
  - Queue emptied; FSM returns to IDLE.
  - All outputs go to 0, except trigger_ready_o, which is 1.
  - overflow_o is cleared.
  - A clear asserted during RUN abandons the job: no done_o and no evt_o are issued for it.
- Queue (FIFO of CW-bit IDs, depth N_CONTEXT):
  - Push when trigger_i && trigger_ready_o.
  - Simultaneous push and pop: both take effect and the count is unchanged.
  - Push while full: ID dropped, queue unchanged, overflow_o set.
  - Read and write pointers wrap modulo N_CONTEXT.
- FSM states: IDLE, START, RUN, DONE.
  - IDLE: if queue non-empty, pop head, latch it into ctx_o, go to START. Otherwise stay.
  - START: start_o=1 for exactly this cycle; go to RUN.
  - RUN: wait for engine_done_i, then go to DONE.
  - DONE: done_o=1 and evt_o[c][0]=1 for all c < N_CORES, this cycle only; evt_o[c][k>0]=0 always. Go to IDLE.
- Dispatch latency: trigger accepted at edge t into an empty queue with FSM idle → pop at cycle t+1 → start_o high in cycle t+2.
- Back-to-back jobs: minimum one IDLE cycle between DONE and the next START.
- Held signals:
  - ctx_o holds its value from START through DONE.
  - ctx_o retains its last value in IDLE; it is don't-care there.
- is_working_o = (state==START || state==RUN).
- engine_done_i outside RUN is ignored.
- engine_done_i coincident with the START cycle is ignored; the engine must not signal done in the cycle of start.
- pending_o excludes the job in flight.
- Duplicate context IDs in the queue are permitted; uniqueness is the regfile's responsibility.

Decomposition:
- hwpe_ctrl_package additions:
  - Enum typedef sched_state_t {IDLE, START, RUN, DONE}.
  - Struct ctrl_sched_t {start; ctx[CW]} for the engine side.
  - Struct flags_sched_t {done; is_working; pending; overflow} for the regfile side, with CW sized from REGFILE_N_MAX_CONTEXT.
- Sub-module hwpe_ctrl_sched_fifo: parametric CW-bit FIFO with push/pop/full/empty/count and synchronous clear. The FSM stays in the top level.

Test Plan:
- Reset with rst_i=1 mid-RUN → all outputs 0 asynchronously, trigger_ready_o=1, no done_o after release.
- Single job: trigger ctx=1 at cycle 0 → start_o at cycle 2 with ctx_o=1; engine_done_i at cycle 10 → done_o and evt_o[c][0]=1 for all 8 cores in cycle 11 only.
- Fill queue: N_CONTEXT=2, FSM in RUN, push 0 then 1 → trigger_ready_o=0, pending_o=2; third trigger → overflow_o=1 and queue unchanged; jobs then dispatch in order 0, 1.
- Simultaneous push/pop: queue holds 1 entry, trigger arrives in the IDLE pop cycle → pending_o stays 1, next dispatch uses the new ID.
- clear_i during RUN with 1 pending → pending_o=0, is_working_o=0, overflow_o=0, no done_o; a later engine_done_i is ignored.
- Spurious engine_done_i in IDLE and START → no state change, no done_o.
